// File: rtl/country_road_car_sensor.sv
// Country-road vehicle sensor: synchronizes a loop detector, debounces presence and counts waiting cars.
// Define SENSOR_DEBOUNCE_EN to build the ARRIVING/LEAVING debounce filter; otherwise loop edges are taken directly.
module country_road_car_sensor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PASS_CYCLES     = 3,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_raw,
    input  logic [1:0]       country,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ARRIVING, PRESENT, LEAVING} state_t;

    localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       PASS_LAST = 8'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_nxt;
    logic       sync1, loop_s;
    logic [7:0] dcnt, dcnt_nxt;
    logic [7:0] pcnt;
    logic       arrival, departure, green, occupied;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            loop_s <= 1'b0;
        end else begin
            sync1  <= loop_raw;
            loop_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // Debounce states stay in the case even in the bypass build; they are simply unreachable there.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        arrival   = 1'b0;
        case (state)
            IDLE: if (loop_s) begin
`ifdef SENSOR_DEBOUNCE_EN
                state_nxt = ARRIVING;
                dcnt_nxt  = '0;
`else
                state_nxt = PRESENT;
                arrival   = 1'b1;
`endif
            end
            ARRIVING: begin
                if (!loop_s) state_nxt = IDLE;
                else if (dcnt == DEB_LAST) begin
                    state_nxt = PRESENT;
                    arrival   = 1'b1;
                end else dcnt_nxt = dcnt + 8'd1;
            end
            PRESENT: if (!loop_s) begin
`ifdef SENSOR_DEBOUNCE_EN
                state_nxt = LEAVING;
                dcnt_nxt  = '0;
`else
                state_nxt = IDLE;
`endif
            end
            LEAVING: begin
                if (loop_s) state_nxt = PRESENT;
                else if (dcnt == DEB_LAST) state_nxt = IDLE;
                else dcnt_nxt = dcnt + 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign green     = (country == 2'b10);
    assign occupied  = (car_count != '0);
    assign departure = green && occupied && (pcnt == PASS_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt      <= '0;
            car_count <= '0;
            x         <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (departure || !(green && occupied)) pcnt <= '0;
            else pcnt <= pcnt + 8'd1;

            overflow <= 1'b0;
            case ({arrival, departure})
                2'b10: begin
                    if (car_count == CNT_MAX) overflow <= 1'b1;
                    else car_count <= car_count + CNT_W'(1);
                end
                2'b01:   car_count <= car_count - CNT_W'(1);
                default: car_count <= car_count;
            endcase

            x <= occupied;
        end
    end

endmodule

// File: tb/tb_country_road_car_sensor.sv
// Directed bench for country_road_car_sensor; expectations follow the build's SENSOR_DEBOUNCE_EN setting.
module tb_country_road_car_sensor;

    localparam int DEB   = 4;
    localparam int PASS  = 3;
    localparam int CW    = 2;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int ARR_EDGE = 2 + DEB + 1;
`else
    localparam int ARR_EDGE = 3;
`endif
    localparam int SETTLE = DEB + 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          loop_raw;
    logic [1:0]    country;
    logic          x;
    logic [CW-1:0] car_count;
    logic          overflow;

    int n_pass  = 0;
    int n_total = 0;

    country_road_car_sensor #(.DEBOUNCE_CYCLES(DEB), .PASS_CYCLES(PASS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .loop_raw(loop_raw), .country(country),
        .x(x), .car_count(car_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive();
        loop_raw = 1'b1;
        repeat (ARR_EDGE + 1) tick();
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; loop_raw = 1'b0; country = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({x, car_count, overflow} !== '0) $display("FAIL reset_hold: got x=%b cnt=%0d ov=%b want 0", x, car_count, overflow);
            else n_pass++;
        end
        reset = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({x, car_count, overflow} !== '0) $display("FAIL reset_release: got x=%b cnt=%0d ov=%b want 0", x, car_count, overflow);
        else n_pass++;
    endtask

    task automatic test_arrival();
        loop_raw = 1'b1;
        repeat (ARR_EDGE - 1) tick();
        n_total++;
        if (car_count !== 2'd0) $display("FAIL arr_early: cnt=%0d want 0", car_count); else n_pass++;
        tick();
        n_total++;
        if (car_count !== 2'd1 || x !== 1'b0) $display("FAIL arr_count: cnt=%0d x=%b want 1/0", car_count, x); else n_pass++;
        tick();
        n_total++;
        if (x !== 1'b1) $display("FAIL arr_x: x=%b want 1", x); else n_pass++;
        repeat (10 - (ARR_EDGE + 1)) tick();
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
        n_total++;
        if (car_count !== 2'd1 || x !== 1'b1) $display("FAIL arr_hold: cnt=%0d x=%b want 1/1", car_count, x); else n_pass++;
    endtask

    task automatic test_glitch();
`ifdef SENSOR_DEBOUNCE_EN
        for (int g = 1; g <= 3; g++) begin
            loop_raw = 1'b1;
            repeat (g) tick();
            loop_raw = 1'b0;
            repeat (SETTLE) tick();
            n_total++;
            if (car_count !== 2'd1) $display("FAIL glitch_%0d: cnt=%0d want 1", g, car_count); else n_pass++;
        end
        loop_raw = 1'b1;
        repeat (ARR_EDGE + 1) tick();
        loop_raw = 1'b0;
        repeat (3) tick();
        loop_raw = 1'b1;
        repeat (SETTLE) tick();
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
        n_total++;
        if (car_count !== 2'd2) $display("FAIL dip_present: cnt=%0d want 2", car_count); else n_pass++;
`else
        loop_raw = 1'b1;
        tick();
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
        n_total++;
        if (car_count !== 2'd2) $display("FAIL bypass_glitch: cnt=%0d want 2", car_count); else n_pass++;
`endif
    endtask

    task automatic test_depart();
        country = 2'b10;
        repeat (2) tick();
        country = 2'b01;
        tick();
        country = 2'b10;
        repeat (2) tick();
        n_total++;
        if (car_count !== 2'd2) $display("FAIL pass_restart: cnt=%0d want 2", car_count); else n_pass++;
        tick();
        n_total++;
        if (car_count !== 2'd1 || x !== 1'b1) $display("FAIL depart_1: cnt=%0d x=%b want 1/1", car_count, x); else n_pass++;
        repeat (3) tick();
        n_total++;
        if (car_count !== 2'd0 || x !== 1'b1) $display("FAIL depart_0: cnt=%0d x=%b want 0/1", car_count, x); else n_pass++;
        tick();
        n_total++;
        if (x !== 1'b0) $display("FAIL depart_x: x=%b want 0", x); else n_pass++;
        repeat (3) tick();
        n_total++;
        if (car_count !== 2'd0) $display("FAIL no_underflow: cnt=%0d want 0", car_count); else n_pass++;
        country = 2'b00;
    endtask

    task automatic test_overflow();
        repeat (3) arrive();
        n_total++;
        if (car_count !== 2'd3) $display("FAIL fill: cnt=%0d want 3", car_count); else n_pass++;
        loop_raw = 1'b1;
        repeat (ARR_EDGE - 1) tick();
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ov_early: ov=%b want 0", overflow); else n_pass++;
        tick();
        n_total++;
        if (overflow !== 1'b1 || car_count !== 2'd3) $display("FAIL ov_pulse: ov=%b cnt=%0d want 1/3", overflow, car_count); else n_pass++;
        tick();
        n_total++;
        if (overflow !== 1'b0 || car_count !== 2'd3) $display("FAIL ov_clear: ov=%b cnt=%0d want 0/3", overflow, car_count); else n_pass++;
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
    endtask

    task automatic test_back_to_back();
        loop_raw = 1'b1;
        repeat (ARR_EDGE - 3) tick();
        country = 2'b10;
        repeat (2) tick();
        n_total++;
        if (car_count !== 2'd3) $display("FAIL coinc_pre: cnt=%0d want 3", car_count); else n_pass++;
        tick();
        n_total++;
        if (car_count !== 2'd3 || overflow !== 1'b0) $display("FAIL coinc: cnt=%0d ov=%b want 3/0", car_count, overflow); else n_pass++;
        repeat (3) tick();
        n_total++;
        if (car_count !== 2'd2) $display("FAIL coinc_next: cnt=%0d want 2", car_count); else n_pass++;
        country = 2'b00;
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
    endtask

    task automatic test_async_reset();
        country = 2'b10;
        tick();
        loop_raw = 1'b1;
        #3 reset = 1'b0;
        #1;
        n_total++;
        if ({x, car_count, overflow} !== '0) $display("FAIL async_reset: x=%b cnt=%0d ov=%b want 0", x, car_count, overflow);
        else n_pass++;
        tick();
        reset = 1'b1;
        repeat (ARR_EDGE - 1) tick();
        n_total++;
        if (car_count !== 2'd0 || x !== 1'b0) $display("FAIL rel_early: cnt=%0d x=%b want 0/0", car_count, x); else n_pass++;
        tick();
        n_total++;
        if (car_count !== 2'd1) $display("FAIL rel_arrival: cnt=%0d want 1", car_count); else n_pass++;
        country = 2'b00;
        loop_raw = 1'b0;
        repeat (SETTLE) tick();
    endtask

    initial begin
        test_reset();
        test_arrival();
        test_glitch();
        test_depart();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
